// File: rtl/sum_until_zero_fsm_pkg.sv
// rtl/sum_until_zero_fsm_pkg.sv - shared defaults and state encodings for the accumulator
package sum_until_zero_fsm_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sum_until_zero_fsm_if.sv
// rtl/sum_until_zero_fsm_if.sv - request, word-stream and result handshake bundle
interface sum_until_zero_fsm_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);

    logic             start;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, in_data, in_valid, out_ready,
        input  in_ready, sum, count, overflow, out_valid, busy
    );

    modport slave (
        input  start, in_data, in_valid, out_ready,
        output in_ready, sum, count, overflow, out_valid, busy
    );

endinterface

// File: rtl/sum_until_zero_fsm_reg_en.sv
// rtl/sum_until_zero_fsm_reg_en.sv - WIDTH-bit register with load enable, cleared by reset
module sum_until_zero_fsm_reg_en #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/sum_until_zero_fsm.sv
// rtl/sum_until_zero_fsm.sv - sums a word stream until a zero word, then offers the result
module sum_until_zero_fsm
    import sum_until_zero_fsm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sum_until_zero_fsm_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             out_valid_q;
    logic             out_valid_d;

    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH:0]   add_full;
    logic             sum_en;
    logic             clear;
    logic             accept;

    assign add_full = {1'b0, sum_q} + {1'b0, bus.in_data};

    // Operand selector: zero on start, otherwise the running sum plus the new word.
    assign sum_next = clear ? '0 : add_full[WIDTH-1:0];

    sum_until_zero_fsm_reg_en #(
        .WIDTH (WIDTH)
    ) u_sum_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sum_en),
        .d     (sum_next),
        .q     (sum_q)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        sum_en     = 1'b0;
        clear      = 1'b0;
        accept     = (state_q == S_ACC) && bus.in_valid;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_ACC;
                    clear      = 1'b1;
                    sum_en     = 1'b1;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            S_ACC: begin
                if (accept) begin
                    if (bus.in_data == '0) begin
                        state_d = S_DONE;
                    end else begin
                        sum_en     = 1'b1;
                        overflow_d = overflow_q | add_full[WIDTH];
                        if (count_q != '1) begin
                            count_d = count_q + CNT_ONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered so it rises on exactly the edge that enters DONE.
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_ACC);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.sum       = sum_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sum_until_zero_fsm.sv
// tb/tb_sum_until_zero_fsm.sv - randomized self-checking bench with a plain-arithmetic sum model
module tb_sum_until_zero_fsm;

    localparam int W = 32;
    localparam int C = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sum_until_zero_fsm_if #(.WIDTH(W), .CNT_W(C)) bus ();

    sum_until_zero_fsm #(.WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: add words as plain integers until the first zero.
    task automatic model(input logic [W-1:0] words[$], output logic [W-1:0] s,
                         output logic [C-1:0] c, output logic o);
        longint unsigned acc = 0;
        int unsigned     n   = 0;
        o = 1'b0;
        foreach (words[i]) begin
            if (words[i] == 0) break;
            acc = acc + longint'(words[i]);
            if (acc >= 64'h1_0000_0000) begin
                o   = 1'b1;
                acc = acc - 64'h1_0000_0000;
            end
            n++;
        end
        s = acc[W-1:0];
        c = (n > 65535) ? 16'hFFFF : n[C-1:0];
    endtask

    task automatic feed(input logic [W-1:0] words[$], input int max_gap);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        foreach (words[i]) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                bus.in_valid = 1'b0;
                bus.in_data  = $urandom;
                bus.start    = 1'($urandom_range(1, 0));
                tick();
            end
            bus.start    = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = words[i];
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({bus.sum, bus.count, bus.overflow, bus.out_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: sum=%0h count=%0d ovf=%b ov=%b, want all 0",
                     bus.sum, bus.count, bus.overflow, bus.out_valid);
        end
        n_tests++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: in_ready=%b busy=%b, want 0 0", bus.in_ready, bus.busy);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [W-1:0] q[$] = '{32'd3, 32'd5, 32'd7, 32'd0};
        logic [W-1:0] s; logic [C-1:0] c; logic o;
        model(q, s, c, o);
        bus.out_ready = 1'b1;
        feed(q, 0);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.sum !== s || bus.count !== c || bus.overflow !== o) begin
            n_fail++;
            $display("FAIL basic_result: ov=%b sum=%0d count=%0d ovf=%b, want 1 %0d %0d %b",
                     bus.out_valid, bus.sum, bus.count, bus.overflow, s, c, o);
        end
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_one_cycle: ov=%b busy=%b, want 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_zero();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_acc: ov=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = '0;
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.sum !== '0 || bus.count !== '0) begin
            n_fail++;
            $display("FAIL zero_result: ov=%b sum=%0d count=%0d, want 1 0 0",
                     bus.out_valid, bus.sum, bus.count);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [W-1:0] q[$] = '{32'hFFFF_FFFF, 32'd2, 32'd0};
        logic [W-1:0] s; logic [C-1:0] c; logic o;
        model(q, s, c, o);
        bus.out_ready = 1'b1;
        feed(q, 0);
        n_tests++;
        if (bus.sum !== s || bus.count !== c || bus.overflow !== o || o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_result: sum=%0h count=%0d ovf=%b, want %0h %0d %b",
                     bus.sum, bus.count, bus.overflow, s, c, o);
        end
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_tests++;
        if (bus.overflow !== 1'b0 || bus.sum !== '0 || bus.count !== '0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b sum=%0h count=%0d busy=%b, want 0 0 0 1",
                     bus.overflow, bus.sum, bus.count, bus.busy);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = '0;
        tick();
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] q[$] = '{32'd10, 32'd0};
        int bad = 0;
        bus.out_ready = 1'b0;
        feed(q, 0);
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.sum !== 32'd10 || bus.in_ready !== 1'b0) bad++;
            bus.start    = 1'(i % 2);
            bus.in_valid = 1'b1;
            bus.in_data  = 32'd99;
            tick();
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        n_tests++;
        if (bad != 0 || bus.out_valid !== 1'b1 || bus.sum !== 32'd10 || bus.count !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_hold: bad_cycles=%0d ov=%b sum=%0d count=%0d, want 0 1 10 1",
                     bad, bus.out_valid, bus.sum, bus.count);
        end
        bus.out_ready = 1'b1;
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== 32'd10) begin
            n_fail++;
            $display("FAIL bp_release: ov=%b busy=%b sum=%0d, want 0 0 10",
                     bus.out_valid, bus.busy, bus.sum);
        end
    endtask

    task automatic test_gaps();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'd4; tick();
        bus.in_valid = 1'b0; bus.in_data = 32'd77;
        tick();
        bus.start = 1'b1; tick();
        bus.start = 1'b0; tick();
        bus.in_valid = 1'b1; bus.in_data = 32'd6; tick();
        bus.in_valid = 1'b0; tick();
        bus.in_valid = 1'b1; bus.in_data = 32'd0; tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 32'd10 || bus.count !== 16'd2) begin
            n_fail++;
            $display("FAIL gaps_result: ov=%b sum=%0d count=%0d, want 1 10 2",
                     bus.out_valid, bus.sum, bus.count);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q[$] = '{32'd9, 32'd0};
        int seen = 0;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = $urandom_range(1000, 1); tick();
        bus.in_data = $urandom_range(1000, 1); tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++;
        if ({bus.sum, bus.count, bus.overflow, bus.out_valid, bus.busy, bus.in_ready} !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: sum=%0d count=%0d ovf=%b ov=%b busy=%b ir=%b, want all 0",
                     bus.sum, bus.count, bus.overflow, bus.out_valid, bus.busy, bus.in_ready);
        end
        repeat (3) begin
            tick();
            if (bus.out_valid !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrst_no_valid: out_valid cycles=%0d, want 0", seen);
        end
        feed(q, 0);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 32'd9 || bus.count !== 16'd1) begin
            n_fail++;
            $display("FAIL midrst_after: ov=%b sum=%0d count=%0d, want 1 9 1",
                     bus.out_valid, bus.sum, bus.count);
        end
        tick();
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            logic [W-1:0] q[$];
            logic [W-1:0] s; logic [C-1:0] c; logic o;
            int len, hold, bad;
            len = $urandom_range(6, 0);
            for (int k = 0; k < len; k++) begin
                logic [W-1:0] w;
                w = ($urandom_range(1, 0) == 1) ? W'($urandom) : W'($urandom_range(100, 1));
                if (w == 0) w = 1;
                q.push_back(w);
            end
            q.push_back('0);
            model(q, s, c, o);
            hold = $urandom_range(3, 0);
            bus.out_ready = 1'b0;
            feed(q, 2);
            bad = 0;
            repeat (hold) begin
                if (bus.out_valid !== 1'b1) bad++;
                tick();
            end
            n_tests++;
            if (bad != 0 || bus.out_valid !== 1'b1 || bus.sum !== s || bus.count !== c ||
                bus.overflow !== o) begin
                n_fail++;
                $display("FAIL rand_%0d: ov=%b sum=%0h count=%0d ovf=%b bad=%0d, want 1 %0h %0d %b 0",
                         t, bus.out_valid, bus.sum, bus.count, bus.overflow, bad, s, c, o);
            end
            bus.out_ready = 1'b1;
            tick();
            n_tests++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_%0d_release: ov=%b busy=%b, want 0 0", t, bus.out_valid, bus.busy);
            end
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_zero();
        test_overflow();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
